// File: rtl/register_sipo_deserializer.sv
// Serial-in, parallel-out receiver for the FPGAMAC register set.
// It collects WIDTH serial bits into a word. Each completed word goes to a
// parallel consumer through a single-entry holding register that uses a
// valid/ready handshake. Every output is driven directly by a flop.
// WIDTH must be in the range 2..16. A 1-bit word has no SHIFT state.
module register_sipo_deserializer #(
   parameter int WIDTH     = 5,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             reg_clk_i,
   input  logic             reg_reset_i,
   input  logic             sdi_i,
   input  logic             sdi_valid_i,
   input  logic             sync_i,
   output logic [WIDTH-1:0] pdo_o,
   output logic             pdo_valid_o,
   input  logic             pdo_ready_i,
   output logic             busy_o,
   output logic             overrun_o,
   input  logic             overrun_clr_i
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Shift state machine. IDLE means the bit count is 0.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Holding register occupancy.
   localparam logic [0:0] HOLD_EMPTY = 1'b0;
   localparam logic [0:0] HOLD_FULL  = 1'b1;

   logic [0:0]       state_q,   state_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [WIDTH-1:0] shift_q,   shift_d;
   logic             busy_q,    busy_d;
   logic [0:0]       hold_q,    hold_d;
   logic [WIDTH-1:0] pdo_q,     pdo_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] shifted;
   logic             word_done;

   // The shift register is all zeros whenever the state is IDLE. This lets
   // the first bit use the same shift expression as every later bit.
   // Applying the same expression to the last bit produces the complete word.
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shift_q[WIDTH-2:0], sdi_i};
      end else begin
         shifted = {sdi_i, shift_q[WIDTH-1:1]};
      end
   end

   // Next state of the bit collector. sync_i takes priority over a valid bit.
   always_comb begin
      // NOTE: every signal gets a default before the branches. An output that
      // is left unassigned on some path in always_comb makes a latch.
      state_d   = state_q;
      count_d   = count_q;
      shift_d   = shift_q;
      word_done = 1'b0;
      if (sync_i) begin
         state_d = ST_IDLE;
         count_d = '0;
         shift_d = '0;
      end else if (sdi_valid_i) begin
         case (state_q)
            ST_IDLE: begin
               shift_d = shifted;
               count_d = CNT_W'(1);
               state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (count_q == CNT_LAST) begin
                  word_done = 1'b1;
                  count_d   = '0;
                  shift_d   = '0;
                  state_d   = ST_IDLE;
               end else begin
                  shift_d = shifted;
                  count_d = count_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
               shift_d = '0;
            end
         endcase
      end
      busy_d = (count_d != '0);
   end

   // Next state of the holding register and the sticky overrun flag.
   // The clear is applied first, so a new overrun in the same cycle wins.
   always_comb begin
      hold_d    = hold_q;
      pdo_d     = pdo_q;
      overrun_d = overrun_clr_i ? 1'b0 : overrun_q;
      if (word_done) begin
         if (hold_q == HOLD_EMPTY || pdo_ready_i) begin
            pdo_d  = shifted;
            hold_d = HOLD_FULL;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (hold_q == HOLD_FULL && pdo_ready_i) begin
         hold_d = HOLD_EMPTY;
      end
   end

   // Bit collector registers. Reset discards any partial word.
   always_ff @(posedge reg_clk_i or posedge reg_reset_i) begin
      // NOTE: state registers use non-blocking assignments. Every flop then
      // samples the values from before the edge, which avoids ordering races.
      if (reg_reset_i) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         shift_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
      end
   end

   // Holding register and overrun flag. Reset also discards a held word.
   always_ff @(posedge reg_clk_i or posedge reg_reset_i) begin
      if (reg_reset_i) begin
         hold_q    <= HOLD_EMPTY;
         pdo_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         pdo_q     <= pdo_d;
         overrun_q <= overrun_d;
      end
   end

   assign pdo_o       = pdo_q;
   assign pdo_valid_o = (hold_q == HOLD_FULL);
   assign busy_o      = busy_q;
   assign overrun_o   = overrun_q;

endmodule

// File: doc/register_sipo_deserializer.md
Name: register_sipo_deserializer

Overview:
- Serial-in, parallel-out receiver: the counterpart of the 5-bit PISO shifter in the FPGAMAC register set.
- Collects WIDTH serial bits, MSB first by default, into a word.
- Hands each completed word to a parallel consumer through a single-entry holding register with a valid/ready handshake.
- Sits between the MAC serial operand/result path and the parallel PIPO operand registers.

Parameters:
- WIDTH, 5: bits per word (2..16).
- MSB_FIRST, 1: 1 = first received bit lands in pdo_o[WIDTH-1] (matches the PISO shift order); 0 = first bit lands in pdo_o[0].

Ports:
- reg_clk_i  input  1  clock; all state updates on posedge.
- reg_reset_i  input  1  asynchronous, active-high reset.
- sdi_i  input  1  serial data bit.
- sdi_valid_i  input  1  sdi_i is sampled on this posedge.
- sync_i  input  1  discard the partial word; restart the bit count at 0.
- pdo_o  output  WIDTH  completed word (holding register).
- pdo_valid_o  output  1  holding register contains an unconsumed word.
- pdo_ready_i  input  1  consumer accepts pdo_o when pdo_valid_o & pdo_ready_i.
- busy_o  output  1  partial word in progress (bit count != 0).
- overrun_o  output  1  sticky: a completed word was dropped because the holding register was full.
- overrun_clr_i  input  1  clears overrun_o.

Behaviour:
- Reset (async, immediate):
  - shift register, bit count, pdo_o = 0.
  - pdo_valid_o, busy_o, overrun_o = 0.
  - Reset mid-word discards everything, including any held word.
- Shift state machine, states IDLE (count=0) and SHIFT (count 1..WIDTH-1):
  - IDLE + sdi_valid_i: capture the bit, count=1, go to SHIFT. WIDTH=1 is not supported.
  - SHIFT + sdi_valid_i, count<WIDTH-1: shift in the bit, count++.
  - SHIFT + sdi_valid_i, count=WIDTH-1: word complete; count=0, go to IDLE. The word is {shift contents, new bit} in the MSB_FIRST order.
  - No sdi_valid_i: hold; there is no timeout.
  - sync_i has priority over sdi_valid_i in the same cycle: count=0, shift register=0, bit ignored, go to IDLE. It does not affect the holding register or overrun_o.
- Holding register (EMPTY/FULL, pdo_valid_o = FULL):
  - Word completes while EMPTY: pdo_o loads on the same posedge; pdo_valid_o=1 from the next cycle. Latency is 1 cycle after the last bit's sampling edge.
  - Word completes while FULL and pdo_ready_i=1 in the same cycle: old word is consumed, new word loads, pdo_valid_o stays 1, no overrun.
  - Word completes while FULL and pdo_ready_i=0: new word dropped, pdo_o unchanged, overrun_o set.
  - pdo_ready_i while FULL with no completion: go to EMPTY. pdo_o keeps its last value; it is not cleared.
  - pdo_o is stable while pdo_valid_o=1 and not accepted.
- overrun_o:
  - Sticky until overrun_clr_i.
  - If overrun_clr_i and a new overrun occur in the same cycle, set wins (overrun_o=1).
- busy_o = (count != 0), registered with the count.
- No combinational path from any input to any output; all outputs are registered.
- Throughput: one word per WIDTH valid bits; back-to-back words need no gap bit.

Test Plan:
1. WIDTH=5, MSB_FIRST=1: feed bits 1,0,1,1,0 on 5 consecutive cycles, pdo_ready_i=0 -> pdo_o=5'b10110 and pdo_valid_o=1 one cycle after the 5th bit; busy_o 1 during bits 2..5, then 0.
2. MSB_FIRST=0, same bit stream -> pdo_o=5'b01101.
3. Hold word 5'b10110 unaccepted, stream 5'b00011 -> pdo_o stays 5'b10110, overrun_o=1. Pulse overrun_clr_i -> overrun_o=0.
4. Hold word, stream the next word with pdo_ready_i=1 exactly on the completing cycle -> pdo_o=new word, pdo_valid_o stays 1, overrun_o stays 0.
5. Send 3 bits, pulse sync_i together with a 4th valid bit, then send 5'b11111 -> pdo_o=5'b11111; busy_o drops the cycle after sync_i.
6. Assert reg_reset_i asynchronously mid-word with a held word -> all outputs 0 immediately. After release, a fresh 5-bit word is received correctly.
